// File: rtl/writeback_regfile_if.sv
// Write-back register file bus.
// Groups the write-back request, load-data strobe, read ports and status
// pulses of writeback_regfile.
//   master : driver side (sequencer / bench) - drives requests and read addresses
//   slave  : register file side - returns read data and status
// Handshake: a request is a single-cycle wr_req sampled only while the
// register file is idle. A c_sel=1 load then waits for Datain_valid.
// Completion is signalled by a one-cycle wb_done or wb_err pulse.
interface writeback_regfile_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        c_sel;
  logic              wr_req;
  logic [2:0]        wr_addr;
  logic              Datain_valid;
  logic [2:0]        rx_addr;
  logic [2:0]        ry_addr;
  logic [DATA_W-1:0] Rx;
  logic [DATA_W-1:0] Ry;
  logic              wb_busy;
  logic              wb_done;
  logic              wb_err;

  modport master (
    output wb_data, c_sel, wr_req, wr_addr, Datain_valid, rx_addr, ry_addr,
    input  Rx, Ry, wb_busy, wb_done, wb_err
  );

  modport slave (
    input  wb_data, c_sel, wr_req, wr_addr, Datain_valid, rx_addr, ry_addr,
    output Rx, Ry, wb_busy, wb_done, wb_err
  );
endinterface

// File: rtl/writeback_regfile.sv
// 8 x DATA_W register file with a write-back controller.
// Non-load sources are written immediately. A bus load (c_sel=1) waits for
// Datain_valid for up to TIMEOUT cycles. If no data arrives, the load is
// aborted and wb_err is pulsed.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : writeback_regfile_if.slave (requests, read ports, status)
//   o_dbg_state : current FSM state (0 IDLE, 1 WAIT_DATA)
module writeback_regfile #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_regfile_if.slave    bus,
  output logic                  o_dbg_state
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [2:0]        r_addr;
  logic [2:0]        w_addr_next;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_we;
  logic [2:0]        w_waddr;
  logic              w_done_set;
  logic              w_err_set;
  logic [DATA_W-1:0] r_regs [8];

  // Next-state, write strobe and status decode
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_we         = 1'b0;
    w_waddr      = bus.wr_addr;
    w_done_set   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.wr_req) begin
          case (bus.c_sel)
            3'd0, 3'd2, 3'd3, 3'd4: begin
              w_we       = 1'b1;
              w_done_set = 1'b1;
            end
            3'd1: begin
              w_addr_next  = bus.wr_addr;
              w_cnt_next   = '0;
              w_state_next = WAIT_DATA;
            end
            default: w_err_set = 1'b1;
          endcase
        end
      end
      WAIT_DATA: begin
        // Data arriving on the last counted cycle still wins over the timeout
        if (bus.Datain_valid) begin
          w_we         = 1'b1;
          w_waddr      = r_addr;
          w_done_set   = 1'b1;
          w_state_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_set    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_busy  <= (w_state_next == WAIT_DATA);
      r_done  <= w_done_set;
      r_err   <= w_err_set;
    end
  end

  // R0 is never written, so it reads back as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_we && (w_waddr != 3'd0)) begin
      r_regs[w_waddr] <= bus.wb_data;
    end
  end

  assign bus.Rx      = r_regs[bus.rx_addr];
  assign bus.Ry      = r_regs[bus.ry_addr];
  assign bus.wb_busy = r_busy;
  assign bus.wb_done = r_done;
  assign bus.wb_err  = r_err;
  assign o_dbg_state = r_state;
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register and data width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles spent waiting for a bus load.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 wb_data  input  DATA_W  SHALL carry the write-back value from the selector mux.
REQ-006 c_sel  input  3  SHALL identify the wb_data source: 0 Result, 1 Datain_Bus, 2 num, 3 Adress_Instruction_Bus, 4 Ry, 5-7 illegal.
REQ-007 wr_req  input  1  SHALL request a write-back; it is sampled only in IDLE.
REQ-008 wr_addr  input  3  SHALL give the destination register R0-R7.
REQ-009 Datain_valid  input  1  SHALL indicate that Datain_Bus, and hence wb_data, holds valid load data.
REQ-010 rx_addr, ry_addr  input  3 each  SHALL give the read-port addresses.
REQ-011 Rx, Ry  output  DATA_W each  SHALL carry the read-port data.
REQ-012 wb_busy  output  1  SHALL be high while waiting for load data.
REQ-013 wb_done  output  1  SHALL pulse for one cycle after each completed write.
REQ-014 wb_err  output  1  SHALL pulse for one cycle after an aborted write (illegal c_sel or timeout).

Function
REQ-015 Storage SHALL be 8 registers of DATA_W bits; R0 SHALL always read 0, and writes to R0 SHALL be discarded but still reported by wb_done.
REQ-016 Rx and Ry SHALL be combinational reads of the stored array with no bypass: a value written at edge N is visible after edge N.
REQ-017 The FSM SHALL have exactly two states: IDLE and WAIT_DATA.
REQ-018 IDLE, wr_req=1, c_sel in {0,2,3,4}:
- wb_data SHALL be written to wr_addr at that edge.
- wb_done SHALL be high for the following cycle.
- The FSM SHALL stay in IDLE.
REQ-019 IDLE, wr_req=1, c_sel=1:
- wr_addr SHALL be latched.
- The timeout counter SHALL be cleared to 0.
- The FSM SHALL go to WAIT_DATA.
- wb_busy SHALL be high from the next cycle.
REQ-020 IDLE, wr_req=1, c_sel in 5-7: there SHALL be no write, wb_err SHALL be high for the following cycle, and the FSM SHALL stay in IDLE.
REQ-021 WAIT_DATA, Datain_valid=1:
- wb_data SHALL be written to the latched address at that edge.
- The FSM SHALL return to IDLE.
- wb_done SHALL pulse; wb_busy SHALL go low.
REQ-022 WAIT_DATA, Datain_valid=0: the counter SHALL increment each cycle. When the counter equals TIMEOUT-1 and Datain_valid=0:
- There SHALL be no write.
- wb_err SHALL pulse.
- The FSM SHALL return to IDLE.
REQ-023 If Datain_valid=1 arrives in the same cycle the counter reaches TIMEOUT-1, the write SHALL win (wb_done, not wb_err).
REQ-024 wr_req, wr_addr and c_sel SHALL be ignored in WAIT_DATA, and Datain_valid SHALL be ignored in IDLE.
REQ-025 Changes to wr_addr while in WAIT_DATA SHALL NOT alter the destination.
REQ-026 The counter SHALL be 4 bits wide, or ceil(log2(TIMEOUT)) bits, and SHALL never wrap while in WAIT_DATA.
REQ-027 wb_done and wb_err SHALL never be high in the same cycle.
REQ-028 wb_busy SHALL be registered and high exactly while the FSM is in WAIT_DATA.

Reset
REQ-029 rst_n=0 SHALL asynchronously:
- clear all registers to 0;
- force the FSM to IDLE;
- clear the counter and the latched address;
- drive wb_busy, wb_done and wb_err to 0.
REQ-030 Reset asserted in WAIT_DATA SHALL abort the load with no write and no wb_err.
REQ-031 After rst_n rises, the first rising edge SHALL act as a normal IDLE edge.

Verification
REQ-032 Reset, then wr_req=1, c_sel=0, wr_addr=3, wb_data=8'hA5 for one cycle -> wb_done pulses next cycle; rx_addr=3 gives Rx=8'hA5.
REQ-033 wr_req=1, c_sel=1, wr_addr=5; Datain_valid=1 with wb_data=8'h3C three cycles later -> wb_busy high for 3 cycles, R5=8'h3C, one wb_done pulse.
REQ-034 c_sel=1 load with Datain_valid held at 0 -> wb_err pulses after 15 cycles in WAIT_DATA; R5 unchanged; wb_busy low afterwards.
REQ-035 wr_req=1, c_sel=6, wr_addr=2 -> wb_err pulse; R2 unchanged. wr_req=1, c_sel=2, wr_addr=0, wb_data=8'hFF -> wb_done pulse; Rx for R0 reads 8'h00.
REQ-036 rst_n driven low mid-WAIT_DATA, then Datain_valid=1 -> no write; all registers 0; wb_busy=0; no wb_done or wb_err.
REQ-037 Datain_valid=1 in the cycle the counter reaches 14 -> write occurs, wb_done pulses, wb_err stays 0.
